eth_reset_sequencer: RTL

//  Power-up and runtime reset sequencer for the Ethernet subsystem. Sits directly upstream of the
//  per-domain reset synchronizers: waits for PLL lock and a debounced push-button release, pulses
//  the external PHY hardware reset, waits for the PHY to come up, then releases sys_rst_n, which

---
 rtl/eth_reset_sequencer.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/eth_reset_sequencer.sv
// Ethernet subsystem reset sequencer.
// Waits for PLL lock and a debounced push-button release. It then pulses the PHY
// hardware reset, waits for the PHY to come up, and finally releases sys_rst_n.
// The sequence re-runs on lock loss, on a button press, or on a soft reset from S_RUN.
module eth_reset_sequencer #(
  parameter int DEBOUNCE_CYC = 16,
  parameter int PHY_RST_CYC  = 500000,
  parameter int PHY_WAIT_CYC = 250000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       btn_rst_n,
  input  logic       soft_rst,
  output logic       phy_rst_n,
  output logic       sys_rst_n,
  output logic       seq_done,
  output logic [1:0] state
);

  localparam int CNT_MAX = (PHY_RST_CYC > PHY_WAIT_CYC) ? PHY_RST_CYC : PHY_WAIT_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int DB_W    = $clog2(DEBOUNCE_CYC + 1);

  // The counters load "cycles - 1" and count down to zero, so zero marks the final cycle.
  localparam logic [CNT_W-1:0] RST_LOAD  = CNT_W'(PHY_RST_CYC - 1);
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(PHY_WAIT_CYC - 1);
  localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);

  typedef enum logic [1:0] {
    S_HOLD     = 2'd0,
    S_PHY_RST  = 2'd1,
    S_PHY_WAIT = 2'd2,
    S_RUN      = 2'd3
  } state_t;

  // Asynchronous inputs. Bit 0 is the PLL lock and bit 1 is the push-button.
  logic [1:0] async_in;
  logic [1:0] sync_out;
  logic       lock_s;
  logic       btn_s;

  assign async_in = {btn_rst_n, pll_locked};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      logic meta_reg;
      logic sync_reg;
      // Two-flop synchronizer. It clears to 0, which reads as "unlocked / pressed".
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          meta_reg <= 1'b0;
          sync_reg <= 1'b0;
        end else begin
          meta_reg <= async_in[gi];
          sync_reg <= meta_reg;
        end
      end
      assign sync_out[gi] = sync_reg;
    end
  endgenerate

  assign lock_s = sync_out[0];
  assign btn_s  = sync_out[1];

  // Debounce logic for the button.
  logic            btn_db_reg;
  logic [DB_W-1:0] db_cnt_reg;

  // The debounced button flips only after DEBOUNCE_CYC consecutive mismatching cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_db_reg <= 1'b0;
      db_cnt_reg <= '0;
    end else if (btn_s == btn_db_reg) begin
      db_cnt_reg <= '0;
    end else if (db_cnt_reg == DB_LAST) begin
      btn_db_reg <= ~btn_db_reg;
      db_cnt_reg <= '0;
    end else begin
      db_cnt_reg <= db_cnt_reg + DB_W'(1);
    end
  end

  logic abort;
  assign abort = !lock_s || !btn_db_reg;

  // Sequencer FSM.
  state_t           state_reg;
  state_t           state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             phy_rst_n_reg;
  logic             sys_rst_n_reg;
  logic             seq_done_reg;

  // Next-state logic. Priority is abort first, then soft_rst, then counter expiry.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    if (abort) begin
      state_next = S_HOLD;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        S_HOLD: begin
          state_next = S_PHY_RST;
          cnt_next   = RST_LOAD;
        end
        S_PHY_RST: begin
          if (cnt_reg == '0) begin
            state_next = S_PHY_WAIT;
            cnt_next   = WAIT_LOAD;
          end else begin
            cnt_next = cnt_reg - CNT_W'(1);
          end
        end
        S_PHY_WAIT: begin
          if (cnt_reg == '0) begin
            state_next = S_RUN;
          end else begin
            cnt_next = cnt_reg - CNT_W'(1);
          end
        end
        S_RUN: begin
          // A soft reset restarts the full PHY pulse and wait sequence.
          if (soft_rst) begin
            state_next = S_PHY_RST;
            cnt_next   = RST_LOAD;
          end
        end
        default: begin
          state_next = S_HOLD;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // State register. The outputs are decoded from next-state, so they move on the same edge as state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_HOLD;
      cnt_reg       <= '0;
      phy_rst_n_reg <= 1'b0;
      sys_rst_n_reg <= 1'b0;
      seq_done_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      phy_rst_n_reg <= (state_next == S_PHY_WAIT) || (state_next == S_RUN);
      sys_rst_n_reg <= (state_next == S_RUN);
      seq_done_reg  <= (state_next == S_RUN);
    end
  end

  assign phy_rst_n = phy_rst_n_reg;
  assign sys_rst_n = sys_rst_n_reg;
  assign seq_done  = seq_done_reg;
  assign state     = state_reg;

endmodule
